fixed_activation_scheduler: RTL
===============================

# fixed_activation_scheduler

Round-robin scheduler that shares one fixed-point activation unit (e.g. `fixed_hardswish`, `fixed_relu`) between `NUM_REQ` independent tensor streams. It grants the unit to one requester for a whole tensor, which keeps tensors contiguous. Each issued beat is tagged with its requester ID so results return to the correct output port. It sits between layer outputs and a single activation instance in area-constrained builds.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_IN_0_PRECISION_0`, 8: element width in bits; passed through unchanged.
- `DATA_IN_0_TENSOR_SIZE_DIM_0`, 8: tensor elements, dimension 0.
- `DATA_IN_0_TENSOR_SIZE_DIM_1`, 4: tensor elements, dimension 1.
- `DATA_IN_0_PARALLELISM_DIM_0`, 1: lanes per beat, dimension 0.
- `DATA_IN_0_PARALLELISM_DIM_1`, 1: lanes per beat, dimension 1.
- `MAX_INFLIGHT`, 4: tag FIFO depth; must be ≥ activation unit pipeline depth + 1.
- Derived: `P = PAR0*PAR1`; `BEATS = (TS0*TS1)/P`; `REQ_W = $clog2(NUM_REQ)`.
- `clk`  in  1  clock.
- `rst`  in  1  reset. Asynchronous, active-high.
- `data_in`  in  [NUM_REQ][P][PRECISION_0]  requester beats.
- `data_in_valid`  in  [NUM_REQ]  per-requester valid.
- `data_in_ready`  out  [NUM_REQ]  per-requester ready.
- `data_out`  out  [NUM_REQ][P][PRECISION_0]  routed results.
- `data_out_valid`  out  [NUM_REQ]  per-requester result valid.
- `data_out_ready`  in  [NUM_REQ]  per-requester result ready.
- `act_in`  out  [P][PRECISION_0]  beat to activation unit.
- `act_in_valid`  out  1  beat to activation unit valid.
- `act_in_ready`  in  1  activation unit ready.
- `act_out`  in  [P][PRECISION_0]  result from activation unit.
- `act_out_valid`  in  1  result from activation unit valid.
- `act_out_ready`  out  1  ready toward activation unit.

## Operation
- FSM states:
  - IDLE: no grant.
  - STREAM: granted requester `g` owns the unit.
- IDLE → STREAM:
  - Condition: any `data_in_valid` is high.
  - `g` = first requester with valid set, searching cyclically from `rr_ptr`.
  - `beat_cnt` ← 0.
- STREAM, forward path (combinational):
  - `act_in = data_in[g]`.
  - `act_in_valid = data_in_valid[g] & !tag_full`.
  - `data_in_ready[g] = act_in_ready & !tag_full`.
  - All other `data_in_ready` are 0.
- Issue: an `act_in` handshake pushes `g` into the tag FIFO and increments `beat_cnt`.
- End of tensor: a handshake with `beat_cnt == BEATS-1` moves the FSM to IDLE and sets `rr_ptr ← (g+1) mod NUM_REQ`.
- Return path, with `h` = tag FIFO head:
  - Broadcast `data_out[k] = act_out` to all k.
  - `data_out_valid[k] = act_out_valid & !tag_empty & (h==k)`.
  - `act_out_ready = !tag_empty & data_out_ready[h]`.
  - A handshake pops the FIFO.
- Tag FIFO full blocks issue.
- While the FIFO is empty, `act_out_ready` = 0 and nothing is routed.
  - A stray `act_out_valid` is held off, never dropped silently.
- Push and pop in the same cycle are both allowed when the FIFO is not full. Occupancy is unchanged.
- Requester deasserting valid mid-tensor: the grant is held and the FSM stays in STREAM until `BEATS` beats are taken. No preemption.
- Reset mid-operation:
  - FSM → IDLE, `rr_ptr`, `beat_cnt` → 0, FIFO emptied.
  - Results still in flight inside the activation unit are not accepted.
  - The activation unit must be reset by the same `rst`.

## Timing
- Reset values: `data_in_ready` = 0, `data_out_valid` = 0, `act_in_valid` = 0, `act_out_ready` = 0. `act_in` and `data_out` are don't-care.
- Arbitration: one-cycle bubble. A request seen in IDLE at cycle t is forwarded at t+1.
- Consecutive tensors always carry one IDLE cycle between them.
- No added data latency: forward and return paths are combinational.
- Throughput: one beat per cycle in STREAM, provided that:
  - `act_in_ready` stays high;
  - results drain;
  - `MAX_INFLIGHT` covers the unit's latency.
- Registers: FSM state, `g`, `rr_ptr`, `beat_cnt` (`$clog2(BEATS)` bits), and FIFO pointers/count.

## Structure
- Package `activation_sched_pkg` holds:
  - the `sched_state_t` enum {IDLE, STREAM};
  - a helper function for the round-robin priority search.
- Sub-module `fixed_act_tag_fifo`: synchronous FIFO.
  - Width `REQ_W`, depth `MAX_INFLIGHT`.
  - Outputs: `full`, `empty`, head.
  - Async active-high reset to empty.

## Test plan
- **Single requester.** `NUM_REQ=4`, `BEATS=32`, requester 2 streams 32 beats through a 2-stage pipelined hardswish model → all 32 results appear only on `data_out_valid[2]`, in order. Exactly 33 cycles from first valid to last issue.
- **Round-robin fairness.** All 4 requesters valid continuously, `rr_ptr`=0 → grant order 0,1,2,3,0. Each tensor is exactly 32 beats with one IDLE cycle between tensors.
- **Backpressure.**
  - Hold `data_out_ready[h]`=0 with `MAX_INFLIGHT`=4 → at most 4 beats are issued, then `act_in_valid`=0.
  - Release → issue resumes the next cycle and no beat is lost.
- **Mid-tensor gaps.** Requester 1 drops valid for 5 cycles after beat 10 → grant stays on 1, other requesters keep `data_in_ready`=0, and the tensor completes with 32 beats.
- **Reset mid-stream.** Assert `rst` after 7 beats with 3 in flight → all outputs are 0 immediately, the FIFO is empty, and the first grant after release goes to the lowest valid requester starting from 0.
- **Stray result.** `act_out_valid`=1 with the FIFO empty → `act_out_ready`=0 and every `data_out_valid`=0.

Source files
------------

// File: rtl/fixed_activation_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// activation_sched_pkg
// Shared types and helpers for the fixed-point activation scheduler.
//   sched_state_t : grant FSM state encoding
//   rr_pick       : cyclic priority search used to pick the next grant
// ---------------------------------------------------------------------------
package activation_sched_pkg;

    // Upper bound on the requester count the priority search can handle.
    localparam int unsigned RR_MAX = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sched_state_t;

    // Returns the first index with valid set, searching upward from ptr and
    // wrapping at n. Returns ptr when nothing is valid (caller gates on |valid).
    function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] valid,
                                            input int unsigned       ptr,
                                            input int unsigned       n);
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && valid[idx]) begin
                    found   = 1'b1;
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/fixed_activation_scheduler_if.sv
// ---------------------------------------------------------------------------
// fixed_activation_scheduler_if
// Bundles the requester, result and activation-unit handshakes of the
// scheduler.
//   slave  : view used by the scheduler itself
//   master : view used by the surrounding logic (requesters, result sinks,
//            activation unit)
// ---------------------------------------------------------------------------
interface fixed_activation_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int P         = 1,
    parameter int PRECISION = 8
);
    logic [NUM_REQ-1:0][P-1:0][PRECISION-1:0] data_in;
    logic [NUM_REQ-1:0]                       data_in_valid;
    logic [NUM_REQ-1:0]                       data_in_ready;
    logic [NUM_REQ-1:0][P-1:0][PRECISION-1:0] data_out;
    logic [NUM_REQ-1:0]                       data_out_valid;
    logic [NUM_REQ-1:0]                       data_out_ready;
    logic [P-1:0][PRECISION-1:0]              act_in;
    logic                                     act_in_valid;
    logic                                     act_in_ready;
    logic [P-1:0][PRECISION-1:0]              act_out;
    logic                                     act_out_valid;
    logic                                     act_out_ready;

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        input  act_in_ready, act_out, act_out_valid,
        output data_in_ready, data_out, data_out_valid,
        output act_in, act_in_valid, act_out_ready
    );

    modport master (
        output data_in, data_in_valid, data_out_ready,
        output act_in_ready, act_out, act_out_valid,
        input  data_in_ready, data_out, data_out_valid,
        input  act_in, act_in_valid, act_out_ready
    );
endinterface

// File: rtl/fixed_act_tag_fifo.sv
// ---------------------------------------------------------------------------
// fixed_act_tag_fifo
// Synchronous FIFO holding the requester ID of every beat currently inside
// the activation unit, so results can be routed back in issue order.
//   clk, rst   : clock, asynchronous active-high reset (to empty)
//   push       : write push_data (ignored when full)
//   pop        : drop head (ignored when empty)
//   full/empty : occupancy flags
//   head       : oldest entry
// ---------------------------------------------------------------------------
module fixed_act_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

// File: rtl/fixed_activation_scheduler.sv
// ---------------------------------------------------------------------------
// fixed_activation_scheduler
// Shares one activation unit between NUM_REQ tensor streams. A requester is
// granted the unit for a whole tensor (BEATS beats); each issued beat's
// requester ID is queued so results return to the right output port.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave view of the requester / result / activation handshakes
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | no grant; pick next requester round-robin from rr_ptr
//   STREAM | requester g owns the unit until BEATS beats are issued
// ---------------------------------------------------------------------------
module fixed_activation_scheduler
    import activation_sched_pkg::*;
#(
    parameter int NUM_REQ                     = 4,
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int MAX_INFLIGHT                = 4
) (
    input logic                           clk,
    input logic                           rst,
    fixed_activation_scheduler_if.slave   bus
);
    localparam int P      = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int BEATS  = (DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1) / P;
    localparam int REQ_W  = $clog2(NUM_REQ);
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    sched_state_t      state, state_n;
    logic [REQ_W-1:0]  g, g_n;
    logic [REQ_W-1:0]  rr_ptr, rr_ptr_n;
    logic [BCNT_W-1:0] beat_cnt, beat_cnt_n;

    logic              tag_full;
    logic              tag_empty;
    logic [REQ_W-1:0]  tag_head;
    logic              issue;
    logic              retire;
    logic              act_in_valid_c;
    logic [NUM_REQ-1:0] data_in_ready_c;
    logic [REQ_W-1:0]  g_pick;

    assign g_pick = REQ_W'(rr_pick(RR_MAX'(bus.data_in_valid), 32'(rr_ptr), NUM_REQ));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            g        <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            g        <= g_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
        end
    end

    always_comb begin
        state_n         = state;
        g_n             = g;
        rr_ptr_n        = rr_ptr;
        beat_cnt_n      = beat_cnt;
        act_in_valid_c  = 1'b0;
        data_in_ready_c = '0;
        issue           = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.data_in_valid) begin
                    state_n    = STREAM;
                    g_n        = g_pick;
                    beat_cnt_n = '0;
                end
            end
            STREAM: begin
                // Grant is held even if the requester drops valid: no preemption.
                act_in_valid_c     = bus.data_in_valid[g] & ~tag_full;
                data_in_ready_c[g] = bus.act_in_ready & ~tag_full;
                issue              = act_in_valid_c & bus.act_in_ready;
                if (issue) begin
                    if (beat_cnt == BCNT_W'(BEATS - 1)) begin
                        state_n  = IDLE;
                        rr_ptr_n = (g == REQ_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
                    end else begin
                        beat_cnt_n = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.act_in        = bus.data_in[g];
    assign bus.act_in_valid  = act_in_valid_c;
    assign bus.data_in_ready = data_in_ready_c;

    // Return path: results are held off while no tag is outstanding, so a
    // stray act_out_valid is never consumed.
    assign bus.act_out_ready = ~tag_empty & bus.data_out_ready[tag_head];
    assign retire            = bus.act_out_valid & bus.act_out_ready;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_route
        assign bus.data_out[k]       = bus.act_out;
        assign bus.data_out_valid[k] = bus.act_out_valid & ~tag_empty &
                                       (tag_head == REQ_W'(k));
    end

    fixed_act_tag_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data (g),
        .pop       (retire),
        .full      (tag_full),
        .empty     (tag_empty),
        .head      (tag_head)
    );
endmodule
